// File: rtl/dr_pkg.sv
// Shared types and helpers for the dual-rail four-phase channel (transmitter and,
// later, receiver).
package dr_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_RTZ  = 2'd2
   } state_t;

   typedef struct packed {
      logic r1;
      logic r0;
   } dr_pair_t;

   // One dual-rail pair. Negative dual-rail is simply the positive code with both rails inverted.
   function automatic dr_pair_t dr_encode(input logic d, input logic spacer);
      dr_pair_t p;
      p.r1 = spacer ? ~d : d;
      p.r0 = spacer ? d : ~d;
      return p;
   endfunction

   function automatic dr_pair_t dr_spacer(input logic spacer);
      dr_pair_t p;
      p.r1 = spacer;
      p.r0 = spacer;
      return p;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/dr_ack_sync.sv
// Multi-flop synchronizer for the asynchronous completion acknowledge.
module dr_ack_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rn,
   input  logic a,
   output logic a_s
);

   logic [SYNC_STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) sr <= '0;
      else     sr <= {sr[SYNC_STAGES-2:0], a};
   end

   assign a_s = sr[SYNC_STAGES-1];

endmodule

// File: rtl/dr_tx_4ph.sv
// Clocked valid/ready to four-phase return-to-spacer dual-rail transmitter.
// Rails come straight from flops; each codeword waits for the synchronized acknowledge.
module dr_tx_4ph
   import dr_pkg::*;
#(
   parameter int W           = 8,
   parameter int SPACER      = 0,
   parameter int SYNC_STAGES = 2,
   parameter int TO_CYCLES   = 1024
) (
   input  logic         clk,
   input  logic         rn,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] dr_1,
   output logic [W-1:0] dr_0,
   input  logic         ack,
   output logic         busy,
   output logic         timeout_err,
   input  logic         clr_err
);

   localparam int            CW     = clog2(TO_CYCLES);
   localparam dr_pair_t      SP     = dr_spacer(SPACER != 0);
   localparam logic [W-1:0]  SP_1   = {W{SP.r1}};
   localparam logic [W-1:0]  SP_0   = {W{SP.r0}};
   localparam logic [CW-1:0] WD_MAX = CW'(TO_CYCLES - 1);
   localparam logic [CW-1:0] WD_PRE = CW'(TO_CYCLES - 2);

   logic          ack_s, primed;
   logic [W-1:0]  hold_data;
   logic          hold_full, hold_full_nxt;
   logic          accept, issue, to_spacer;
   logic [W-1:0]  code_1, code_0;
   logic [CW-1:0] wd_cnt;
   state_t        state, state_nxt;

   dr_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rn  (rn),
      .a   (ack),
      .a_s (ack_s)
   );

   // A constant-one chain of the same depth marks when ack_s carries a real
   // post-reset sample, so a still-high acknowledge from an aborted word is
   // never mistaken for a completed return-to-spacer.
   dr_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_prime (
      .clk (clk),
      .rn  (rn),
      .a   (1'b1),
      .a_s (primed)
   );

   for (genvar i = 0; i < W; i++) begin : g_lane
      assign {code_1[i], code_0[i]} = dr_encode(hold_data[i], SPACER != 0);
   end

   assign accept        = in_valid & in_ready;
   assign hold_full_nxt = accept ? 1'b1 : (issue ? 1'b0 : hold_full);
   assign busy          = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      to_spacer = 1'b0;
      case (state)
         S_IDLE: if (hold_full && !ack_s) begin
            issue     = 1'b1;
            state_nxt = S_DATA;
         end
         S_DATA: if (ack_s) begin
            to_spacer = 1'b1;
            state_nxt = S_RTZ;
         end
         S_RTZ:  if (primed && !ack_s) state_nxt = S_IDLE;
         default: state_nxt = S_RTZ;
      endcase
   end

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) state <= S_RTZ;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         hold_data <= '0;
         hold_full <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         if (accept) hold_data <= in_data;
         hold_full <= hold_full_nxt;
         in_ready  <= !hold_full_nxt;
      end
   end

   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         dr_1 <= SP_1;
         dr_0 <= SP_0;
      end else if (issue) begin
         dr_1 <= code_1;
         dr_0 <= code_0;
      end else if (to_spacer) begin
         dr_1 <= SP_1;
         dr_0 <= SP_0;
      end
   end

   // Watchdog restarts on every state change and saturates at its limit.
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else if (clr_err) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else if (state == S_IDLE || state_nxt != state) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
         wd_cnt <= wd_cnt + CW'(1);
         if (wd_cnt == WD_PRE) timeout_err <= 1'b1;
      end
   end

endmodule
